// File: rtl/fa.sv
// One-bit full adder used as the single arithmetic cell of serial_add_seq.
module fa (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic SUM,
    output logic CARRY
);

    assign SUM   = A ^ B ^ C;
    assign CARRY = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder/subtractor: one full adder, LSB-first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to honour SUB (A - B); otherwise every operation is A + B.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             fa_sum, fa_carry;
    logic             sub_op;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_op = SUB;
`else
    logic unused_sub;
    assign unused_sub = SUB;
    assign sub_op     = 1'b0;
`endif

    fa u_fa (
        .A     (a_q[0]),
        .B     (b_q[0]),
        .C     (carry_q),
        .SUM   (fa_sum),
        .CARRY (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    a_d     = A;
                    b_d     = sub_op ? ~B : B;
                    carry_d = sub_op;  // +1 completes the two's-complement negation of B
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = {fa_sum, r_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_sum, r_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;  // carry into MSB vs carry out of MSB
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: cycle-level model compare on an 8-bit instance plus
// directed literal checks and an exhaustive sweep on a 4-bit instance.
module tb_serial_add_seq;

`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .CLR(clr), .START(start8), .SUB(sub8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8), .OVF(ovf8)
    );

    serial_add_seq #(.WIDTH(4)) u_dut4 (
        .CLK(clk), .CLR(clr), .START(start4), .SUB(sub4), .A(a4), .B(b4),
        .BUSY(busy4), .DONE(done4), .SUM(sum4), .COUT(cout4), .OVF(ovf4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // {ovf, cout, sum} of a WIDTH-bit two's-complement add/subtract, from plain arithmetic.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic       ci;
        logic [7:0] ob;
        logic [8:0] full;
        ci   = s & SUB_EN;
        ob   = ci ? ~b : b;
        full = {1'b0, a} + {1'b0, ob} + {8'd0, ci};
        return {((a[7] == ob[7]) && (full[7] != a[7])), full[8], full[7:0]};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic       ci;
        logic [3:0] ob;
        logic [4:0] full;
        ci   = s & SUB_EN;
        ob   = ci ? ~b : b;
        full = {1'b0, a} + {1'b0, ob} + {4'd0, ci};
        return {((a[3] == ob[3]) && (full[3] != a[3])), full[4], full[3:0]};
    endfunction

    // Transaction-level model: an accepted request produces its result WIDTH edges later.
    int         m_left = 0;
    logic       m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_sum = '0;
    logic [9:0] m_pend = '0;

    always @(posedge clk) begin
        if (clr) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_sum  <= m_pend[7:0];
                    m_cout <= m_pend[8];
                    m_ovf  <= m_pend[9];
                end
            end else if (start8) begin
                m_pend <= ref8(a8, b8, sub8);
                m_left <= 8;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy8}, {31'd0, m_busy});
            chk("model_done", {31'd0, done8}, {31'd0, m_done});
            chk("model_sum", {24'd0, sum8}, {24'd0, m_sum});
            chk("model_cout", {31'd0, cout8}, {31'd0, m_cout});
            chk("model_ovf", {31'd0, ovf8}, {31'd0, m_ovf});
            chk("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Returns at the negedge inside the DONE cycle; nbusy counts busy cycles seen before it.
    task automatic wait_done8(output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1'b1;
                break;
            end
            if (busy8) nbusy++;
        end
        if (!ok) chk("done8_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_done8(input int cycles, output int ndone);
        ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
    endtask

    task automatic chk_res8(input string name, input logic [7:0] s, input logic c,
                            input logic v);
        chk({name, "_sum"}, {24'd0, sum8}, {24'd0, s});
        chk({name, "_cout"}, {31'd0, cout8}, {31'd0, c});
        chk({name, "_ovf"}, {31'd0, ovf8}, {31'd0, v});
    endtask

    initial begin
        int nb;
        int nd;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk_res8("rst", 8'h00, 1'b0, 1'b0);
        chk("rst_sum4", {28'd0, sum4}, 32'd0);

        op8(8'h5A, 8'h3C, 1'b0);
        wait_done8(nb);
        chk("add1_busy_cycles", nb, 32'd8);
        chk_res8("add1", 8'h96, 1'b0, 1'b1);

        op8(8'hFF, 8'h01, 1'b0);
        wait_done8(nb);
        chk_res8("wrap", 8'h00, 1'b1, 1'b0);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;  // request inside the DONE cycle
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8(nb);
        chk("b2b_busy_cycles", nb, 32'd8);
        chk_res8("b2b", 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        op8(8'h10, 8'h20, 1'b1);
        wait_done8(nb);
        chk_res8("sub1", 8'hF0, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1);
        wait_done8(nb);
        chk_res8("sub2", 8'h7F, 1'b1, 1'b1);
`else
        op8(8'h10, 8'h20, 1'b1);
        wait_done8(nb);
        chk_res8("nosub", 8'h30, 1'b0, 1'b0);
`endif

        op8(8'h5A, 8'h3C, 1'b0);
        repeat (2) @(posedge clk);
        #1 a8 = 8'h11; b8 = 8'h00; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        wait_done8(nb);
        chk_res8("ignored_start", 8'h96, 1'b0, 1'b1);
        count_done8(12, nd);
        chk("ignored_extra_done", nd, 32'd0);

        op8(8'hFF, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk_res8("abort", 8'h00, 1'b0, 1'b0);
        count_done8(12, nd);
        chk("abort_no_done", nd, 32'd0);
        op8(8'h5A, 8'h3C, 1'b0);
        wait_done8(nb);
        chk_res8("after_abort", 8'h96, 1'b0, 1'b1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    bit ok = 1'b0;
                    a4 = 4'(a); b4 = 4'(b); sub4 = s[0]; start4 = 1'b1;
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk);
                        if (done4) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    if (!ok) chk("done4_timeout", 32'd0, 32'd1);
                    chk("sweep4", {26'd0, ovf4, cout4, sum4},
                        {26'd0, ref4(4'(a), 4'(b), s[0])});
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
